// File: rtl/dg_pkg.sv
// Shared definitions for DG-series core blocks.
// Provides op encodings and modulo-pointer helpers for any depth.
package dg_pkg;

    // Stack operation encoding, formed as {pop, push}
    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_PUSH = 2'b01;
    localparam logic [1:0] OP_POP  = 2'b10;
    localparam logic [1:0] OP_REPL = 2'b11;

    // Increment with exact wrap at depth-1 -> 0 (depth need not be 2^n)
    function automatic int unsigned dg_mod_inc(
        input int unsigned ptr,
        input int unsigned depth
    );
        return (ptr >= depth - 1) ? 0 : ptr + 1;
    endfunction

    // Decrement with exact wrap at 0 -> depth-1
    function automatic int unsigned dg_mod_dec(
        input int unsigned ptr,
        input int unsigned depth
    );
        return (ptr == 0) ? depth - 1 : ptr - 1;
    endfunction

endpackage

// File: rtl/dg_return_stack.sv
// Return-address stack: circular buffer with level count, sticky
// ovf/udf flags, selectable overflow policy and a debug peek port.
// Ports: clk, rst_n (sync, active low), ena, push, pop, din, clr_err,
//        peek_idx -> tos, peek_data, level, empty, full, ovf, udf.
module dg_return_stack #(
    parameter  int WIDTH    = 10,
    parameter  int DEPTH    = 5,
    parameter  bit OVF_DROP = 1'b1,
    localparam int LVL_W    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    input  logic             clr_err,
    input  logic [LVL_W-1:0] peek_idx,
    output logic [WIDTH-1:0] tos,
    output logic [WIDTH-1:0] peek_data,
    output logic [LVL_W-1:0] level,
    output logic             empty,
    output logic             full,
    output logic             ovf,
    output logic             udf
);
    import dg_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int SUM_W = LVL_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];

    // wp is the next free slot; the top entry lives one below it
    logic [PTR_W-1:0] wp;
    logic [PTR_W-1:0] wp_n;
    logic [PTR_W-1:0] wp_inc;
    logic [PTR_W-1:0] top_ptr;
    logic [PTR_W-1:0] wr_addr;
    logic [PTR_W-1:0] pk_ptr;
    logic [SUM_W-1:0] pk_sum;
    logic [LVL_W-1:0] level_n;
    logic [1:0]       op;
    logic             wr_en;
    logic             ovf_set;
    logic             udf_set;
    logic             pk_hit;

    assign op      = {pop, push};
    assign wp_inc  = PTR_W'(dg_mod_inc(32'(wp), DEPTH));
    assign top_ptr = PTR_W'(dg_mod_dec(32'(wp), DEPTH));

    assign empty = (level == '0);
    assign full  = (level == LVL_W'(DEPTH));
    assign tos   = empty ? '0 : mem[top_ptr];

    // Peek slot = wp - 1 - k (mod DEPTH); biased by DEPTH so it never
    // goes negative while k < level <= DEPTH.
    assign pk_hit = (peek_idx < level);

    always_comb begin
        pk_sum = SUM_W'(wp) + SUM_W'(DEPTH - 1) - SUM_W'(peek_idx);
        pk_ptr = '0;
        if (pk_hit) begin
            if (pk_sum >= SUM_W'(DEPTH)) begin
                pk_ptr = PTR_W'(pk_sum - SUM_W'(DEPTH));
            end else begin
                pk_ptr = PTR_W'(pk_sum);
            end
        end
    end

    assign peek_data = pk_hit ? mem[pk_ptr] : '0;

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = wp;
        wp_n    = wp;
        level_n = level;
        ovf_set = 1'b0;
        udf_set = 1'b0;
        if (rst_n && ena) begin
            case (op)
                OP_PUSH: begin
                    if (!full) begin
                        wr_en   = 1'b1;
                        wp_n    = wp_inc;
                        level_n = level + LVL_W'(1);
                    end else begin
                        ovf_set = 1'b1;
                        // When full, wp aliases the oldest slot
                        if (OVF_DROP) begin
                            wr_en = 1'b1;
                            wp_n  = wp_inc;
                        end
                    end
                end
                OP_POP: begin
                    if (!empty) begin
                        wp_n    = top_ptr;
                        level_n = level - LVL_W'(1);
                    end else begin
                        udf_set = 1'b1;
                    end
                end
                OP_REPL: begin
                    wr_en = 1'b1;
                    if (!empty) begin
                        wr_addr = top_ptr;
                    end else begin
                        wp_n    = wp_inc;
                        level_n = LVL_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wp    <= '0;
            level <= '0;
            ovf   <= 1'b0;
            udf   <= 1'b0;
        end else if (ena) begin
            wp    <= wp_n;
            level <= level_n;
            ovf   <= ovf_set | (ovf & ~clr_err);
            udf   <= udf_set | (udf & ~clr_err);
        end
    end

    // Storage is not reset; level=0 masks stale contents
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= din;
        end
    end

endmodule

// File: tb/tb_dg_return_stack.sv
// Scoreboard bench for dg_return_stack: three builds (D5 drop, D5
// reject, D3 drop) share stimulus and are checked against list models.
module tb_dg_return_stack;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic       clr_err = 1'b0;
    logic [9:0] din = '0;
    logic [2:0] peek_idx = '0;

    always #5 clk = ~clk;

    logic [9:0] a_tos [3];
    logic [9:0] a_pk  [3];
    logic [2:0] a_lvl [3];
    logic       a_e [3];
    logic       a_f [3];
    logic       a_o [3];
    logic       a_u [3];
    logic [1:0] lvl2;

    assign a_lvl[2] = {1'b0, lvl2};

    dg_return_stack #(.WIDTH(10), .DEPTH(5), .OVF_DROP(1'b1)) u0 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .push(push), .pop(pop),
        .din(din), .clr_err(clr_err), .peek_idx(peek_idx),
        .tos(a_tos[0]), .peek_data(a_pk[0]), .level(a_lvl[0]),
        .empty(a_e[0]), .full(a_f[0]), .ovf(a_o[0]), .udf(a_u[0])
    );

    dg_return_stack #(.WIDTH(10), .DEPTH(5), .OVF_DROP(1'b0)) u1 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .push(push), .pop(pop),
        .din(din), .clr_err(clr_err), .peek_idx(peek_idx),
        .tos(a_tos[1]), .peek_data(a_pk[1]), .level(a_lvl[1]),
        .empty(a_e[1]), .full(a_f[1]), .ovf(a_o[1]), .udf(a_u[1])
    );

    dg_return_stack #(.WIDTH(10), .DEPTH(3), .OVF_DROP(1'b1)) u2 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .push(push), .pop(pop),
        .din(din), .clr_err(clr_err), .peek_idx(peek_idx[1:0]),
        .tos(a_tos[2]), .peek_data(a_pk[2]), .level(lvl2),
        .empty(a_e[2]), .full(a_f[2]), .ovf(a_o[2]), .udf(a_u[2])
    );

    typedef struct packed {
        logic [1:0] inst;
        logic [9:0] tos;
        logic [9:0] peek;
        logic [2:0] lvl;
        logic       e;
        logic       f;
        logic       o;
        logic       u;
    } exp_t;

    exp_t exq [$];

    int vectors = 0;
    int miscompares = 0;

    // Reference model: ms[i][0] is the bottom, ms[i][lev-1] the top
    logic [9:0] ms [3][8];
    int         mlev [3];
    bit         movf [3];
    bit         mudf [3];
    int         mdep [3] = '{5, 5, 3};
    bit         mdrop [3] = '{1'b1, 1'b0, 1'b1};

    task automatic model_step(input int i, input bit r, input bit e,
                              input bit pu, input bit po, input bit cl,
                              input logic [9:0] d);
        int dep;
        dep = mdep[i];
        if (!r) begin
            mlev[i] = 0;
            movf[i] = 0;
            mudf[i] = 0;
        end else if (e) begin
            if (cl) begin
                movf[i] = 0;
                mudf[i] = 0;
            end
            if (pu && po) begin
                if (mlev[i] > 0) begin
                    ms[i][mlev[i]-1] = d;
                end else begin
                    ms[i][0] = d;
                    mlev[i]  = 1;
                end
            end else if (pu) begin
                if (mlev[i] < dep) begin
                    ms[i][mlev[i]] = d;
                    mlev[i]++;
                end else begin
                    movf[i] = 1;
                    if (mdrop[i]) begin
                        for (int k = 0; k < dep - 1; k++) ms[i][k] = ms[i][k+1];
                        ms[i][dep-1] = d;
                    end
                end
            end else if (po) begin
                if (mlev[i] > 0) mlev[i]--;
                else mudf[i] = 1;
            end
        end
    endtask

    function automatic exp_t model_out(input int i, input int pk);
        exp_t x;
        int   k;
        k = (i == 2) ? (pk & 3) : pk;
        x.inst = 2'(i);
        x.tos  = (mlev[i] > 0) ? ms[i][mlev[i]-1] : 10'h000;
        x.peek = (k < mlev[i]) ? ms[i][mlev[i]-1-k] : 10'h000;
        x.lvl  = 3'(mlev[i]);
        x.e    = (mlev[i] == 0);
        x.f    = (mlev[i] == mdep[i]);
        x.o    = movf[i];
        x.u    = mudf[i];
        return x;
    endfunction

    task automatic step(input bit r, input bit e, input bit pu,
                        input bit po, input bit cl, input logic [9:0] d,
                        input logic [2:0] pk);
        @(negedge clk);
        rst_n = r; ena = e; push = pu; pop = po;
        clr_err = cl; din = d; peek_idx = pk;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            model_step(i, r, e, pu, po, cl, d);
            exq.push_back(model_out(i, int'(pk)));
        end
    endtask

    task automatic chk(input string nm, input int i, input int act,
                       input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s[u%0d] at %0t: got %0h, expected %0h",
                     nm, i, $time, act, exp);
        end
    endtask

    // Monitor: outputs settle right after the edge they were issued on
    initial begin
        exp_t x;
        int   i;
        forever begin
            @(posedge clk);
            #1;
            while (exq.size() > 0) begin
                x = exq.pop_front();
                i = int'(x.inst);
                chk("tos",   i, int'(a_tos[i]), int'(x.tos));
                chk("peek",  i, int'(a_pk[i]),  int'(x.peek));
                chk("level", i, int'(a_lvl[i]), int'(x.lvl));
                chk("empty", i, int'(a_e[i]),   int'(x.e));
                chk("full",  i, int'(a_f[i]),   int'(x.f));
                chk("ovf",   i, int'(a_o[i]),   int'(x.o));
                chk("udf",   i, int'(a_u[i]),   int'(x.u));
            end
        end
    end

    initial begin
        // 1: basic push/pop
        step(0, 1, 0, 0, 0, 10'h000, 3'd0);
        step(1, 1, 1, 0, 0, 10'h101, 3'd0);
        step(1, 1, 1, 0, 0, 10'h102, 3'd1);
        step(1, 1, 1, 0, 0, 10'h103, 3'd2);
        for (int n = 0; n < 3; n++) step(1, 1, 0, 1, 0, 10'h000, 3'd0);

        // 2: overflow policy
        step(0, 1, 0, 0, 0, 10'h000, 3'd0);
        for (int n = 1; n <= 6; n++) step(1, 1, 1, 0, 0, 10'(n), 3'd0);
        step(1, 1, 0, 0, 0, 10'h000, 3'd4);
        for (int n = 0; n < 5; n++) step(1, 1, 0, 1, 0, 10'h000, 3'd0);

        // 3: underflow and clr_err precedence
        step(0, 1, 0, 0, 0, 10'h000, 3'd0);
        step(1, 1, 0, 1, 0, 10'h000, 3'd0);
        step(1, 1, 0, 0, 1, 10'h000, 3'd0);
        step(1, 1, 0, 1, 1, 10'h000, 3'd0);

        // 4: replace
        step(0, 1, 0, 0, 0, 10'h000, 3'd0);
        step(1, 1, 1, 0, 0, 10'h0AA, 3'd0);
        step(1, 1, 1, 0, 0, 10'h0BB, 3'd0);
        step(1, 1, 1, 1, 0, 10'h3FF, 3'd1);
        step(0, 1, 0, 0, 0, 10'h000, 3'd0);
        step(1, 1, 1, 1, 0, 10'h155, 3'd0);

        // 5: ena hold, then reset mid-sequence
        step(0, 1, 0, 0, 0, 10'h000, 3'd0);
        for (int n = 0; n < 4; n++) step(1, 1, 1, 0, 0, 10'(n + 'h20), 3'd1);
        step(1, 1, 0, 1, 0, 10'h000, 3'd0);
        step(1, 1, 1, 0, 0, 10'h2C3, 3'd3);
        for (int n = 0; n < 3; n++) step(1, 0, n != 1, n != 0, 1, 10'h3A5, 3'd2);
        step(0, 1, 1, 0, 0, 10'h111, 3'd0);
        step(1, 1, 0, 0, 0, 10'h000, 3'd0);

        // 6: random traffic, crosses wrap points of both depths
        for (int n = 0; n < 400; n++) begin
            int  rr;
            bit  r, e, pu, po, cl;
            rr = int'($urandom_range(0, 99));
            r  = ($urandom_range(0, 99) >= 2);
            e  = ($urandom_range(0, 99) >= 8);
            cl = ($urandom_range(0, 99) < 6);
            pu = (rr < 55);
            po = (rr >= 40 && rr < 85);
            step(r, e, pu, po, cl, 10'($urandom()), 3'($urandom_range(0, 7)));
        end

        @(negedge clk);
        rst_n = 1'b1; ena = 1'b0;
        @(posedge clk);
        #3;
        if (exq.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected entries left", exq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
